// File: rtl/wb_arbiter_rr_pkg.sv
// Shared types for the round-robin Wishbone arbiter: FSM encoding and
// watchdog counter sizing.
package wb_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // A disabled watchdog still gets a 1-bit counter so the declaration stays legal.
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// Bundle of upstream (s_*) and downstream (m_*) Wishbone signals around the
// arbiter; the slave modport is the arbiter's view, master is the environment's.
interface wb_arbiter_rr_if #(
    parameter int N  = 2,
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_wdata;
    logic [DW-1:0]   s_rdata;
    logic [N-1:0]    s_cyc;
    logic [N-1:0]    s_we;
    logic [N-1:0]    s_ack;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_cyc;
    logic            m_we;
    logic            m_ack;
    logic            err;

    modport slave (
        input  s_addr, s_wdata, s_cyc, s_we, m_rdata, m_ack,
        output s_rdata, s_ack, m_addr, m_wdata, m_cyc, m_we, err
    );

    modport master (
        output s_addr, s_wdata, s_cyc, s_we, m_rdata, m_ack,
        input  s_rdata, s_ack, m_addr, m_wdata, m_cyc, m_we, err
    );
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward
// from (last+1) mod N with wrap.
module arb_rr_pick #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic          valid,
    output logic [LW-1:0] idx
);

    // Priority scan; the first hit in rotation order wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(last) + k) % N]) begin
                valid = 1'b1;
                idx   = LW'((int'(last) + k) % N);
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// N-master round-robin Wishbone arbiter with latched request, a mandatory
// post-transfer gap cycle and an optional watchdog.
module wb_arbiter_rr
    import wb_arbiter_rr_pkg::*;
#(
    parameter int N       = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    wb_arbiter_rr_if.slave    bus
);

    localparam int              LW       = $clog2(N);
    localparam int              CW       = cnt_width(TIMEOUT);
    localparam bit              WDOG_EN  = (TIMEOUT > 0);
    localparam logic [CW-1:0]   CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

    arb_state_t     state_r;
    logic [LW-1:0]  grant_r;
    logic [LW-1:0]  last_r;
    logic [CW-1:0]  cnt_r;
    logic [AW-1:0]  m_addr_r;
    logic [DW-1:0]  m_wdata_r;
    logic           m_we_r;
    logic           m_cyc_r;

    logic           pick_valid_s;
    logic [LW-1:0]  pick_idx_s;
    logic           ack_s;
    logic           expire_s;
    logic [N-1:0]   s_ack_s;
    logic [DW-1:0]  s_rdata_s;

    arb_rr_pick #(.N(N), .LW(LW)) u_pick (
        .req   (bus.s_cyc),
        .last  (last_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // A genuine ack always beats watchdog expiry in the same cycle.
    assign ack_s    = (state_r == ST_BUSY) && bus.m_ack;
    assign expire_s = WDOG_EN && (state_r == ST_BUSY) && !bus.m_ack && (cnt_r == CNT_LAST);

    // Upstream ack and read data; ack is swallowed if the master has already gone away.
    always_comb begin
        s_ack_s   = '0;
        s_rdata_s = '0;
        if ((ack_s || expire_s) && bus.s_cyc[grant_r]) begin
            s_ack_s[grant_r] = 1'b1;
        end else begin
            s_ack_s = '0;
        end
        if (ack_s) begin
            s_rdata_s = bus.m_rdata;
        end else if (expire_s) begin
            s_rdata_s = {DW{1'b1}};
        end else begin
            s_rdata_s = '0;
        end
    end

    // Arbitration FSM with the latched downstream request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            last_r    <= LW'(N - 1);
            cnt_r     <= '0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
            m_we_r    <= 1'b0;
            m_cyc_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        grant_r   <= pick_idx_s;
                        last_r    <= pick_idx_s;
                        m_addr_r  <= bus.s_addr[pick_idx_s*AW +: AW];
                        m_wdata_r <= bus.s_wdata[pick_idx_s*DW +: DW];
                        m_we_r    <= bus.s_we[pick_idx_s];
                        m_cyc_r   <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (ack_s || expire_s) begin
                        m_cyc_r <= 1'b0;
                        state_r <= ST_GAP;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    m_cyc_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.m_addr  = m_addr_r;
    assign bus.m_wdata = m_wdata_r;
    assign bus.m_we    = m_we_r;
    assign bus.m_cyc   = m_cyc_r;
    assign bus.s_ack   = s_ack_s;
    assign bus.s_rdata = s_rdata_s;
    assign bus.err     = expire_s;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed bench for wb_arbiter_rr (N=3, TIMEOUT=8): fairness, single master,
// abort, watchdog, ack/expiry collision and reset in flight.
module tb_wb_arbiter_rr;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [15:0] fair_addr [3];
    logic [15:0] fair_ack  [3];

    wb_arbiter_rr_if #(.N(3), .AW(16), .DW(16)) bus ();

    wb_arbiter_rr #(.N(3), .AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        fair_addr[0] = 16'h1000; fair_addr[1] = 16'h2000; fair_addr[2] = 16'h3000;
        fair_ack[0]  = 16'h0001; fair_ack[1]  = 16'h0002; fair_ack[2]  = 16'h0004;
        rst         = 1'b1;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_cyc   = 3'b000;
        bus.s_we    = 3'b000;
        bus.m_rdata = 16'h0000;
        bus.m_ack   = 1'b0;
        tick(); tick();
        #1;
        chk("rst_m_cyc",   16'(bus.m_cyc),   16'h0000);
        chk("rst_m_addr",  bus.m_addr,       16'h0000);
        chk("rst_s_ack",   16'(bus.s_ack),   16'h0000);
        chk("rst_err",     16'(bus.err),     16'h0000);
        chk("rst_s_rdata", bus.s_rdata,      16'h0000);
        rst = 1'b0;

        // Fairness: everyone requests, slave acks immediately.
        bus.s_addr = {16'h3000, 16'h2000, 16'h1000};
        bus.s_cyc  = 3'b111;
        for (int r = 0; r < 6; r++) begin
            tick();
            bus.m_ack   = 1'b1;
            bus.m_rdata = 16'hA000 + 16'(r);
            #1;
            chk("fair_m_cyc",   16'(bus.m_cyc), 16'h0001);
            chk("fair_m_addr",  bus.m_addr,     fair_addr[r % 3]);
            chk("fair_s_ack",   16'(bus.s_ack), fair_ack[r % 3]);
            chk("fair_s_rdata", bus.s_rdata,    16'hA000 + 16'(r));
            tick();
            bus.m_ack = 1'b0;
            #1;
            chk("fair_gap_m_cyc", 16'(bus.m_cyc), 16'h0000);
            chk("fair_gap_s_ack", 16'(bus.s_ack), 16'h0000);
            tick();
            #1;
            chk("fair_idle_m_cyc", 16'(bus.m_cyc), 16'h0000);
        end
        bus.s_cyc = 3'b000;
        tick();

        // Single master, read, ack in third BUSY cycle.
        bus.s_addr  = {16'h0000, 16'h0000, 16'h1234};
        bus.s_we    = 3'b000;
        bus.s_cyc   = 3'b001;
        bus.m_rdata = 16'hBEEF;
        #1;
        chk("sm_pre_m_cyc", 16'(bus.m_cyc), 16'h0000);
        tick();
        bus.s_addr = {16'h0000, 16'h0000, 16'hFFFF};
        #1;
        chk("sm_m_cyc",   16'(bus.m_cyc), 16'h0001);
        chk("sm_m_addr",  bus.m_addr,     16'h1234);
        chk("sm_m_we",    16'(bus.m_we),  16'h0000);
        chk("sm_s_ack0",  16'(bus.s_ack), 16'h0000);
        chk("sm_rdata0",  bus.s_rdata,    16'h0000);
        tick();
        #1;
        chk("sm_s_ack1",  16'(bus.s_ack), 16'h0000);
        tick();
        bus.m_ack = 1'b1;
        #1;
        chk("sm_s_ack",   16'(bus.s_ack), 16'h0001);
        chk("sm_s_rdata", bus.s_rdata,    16'hBEEF);
        chk("sm_err",     16'(bus.err),   16'h0000);
        chk("sm_m_addr_held", bus.m_addr, 16'h1234);
        tick();
        bus.m_ack = 1'b0;
        bus.s_cyc = 3'b000;
        #1;
        chk("sm_gap_m_cyc",  16'(bus.m_cyc), 16'h0000);
        chk("sm_gap_rdata",  bus.s_rdata,    16'h0000);
        tick();

        // Abort: master 1 writes, then drops cyc one cycle after grant.
        bus.s_addr  = {16'h0000, 16'h5555, 16'h0000};
        bus.s_wdata = {16'h0000, 16'h00AA, 16'h0000};
        bus.s_we    = 3'b010;
        bus.s_cyc   = 3'b010;
        tick();
        #1;
        chk("ab_m_cyc",   16'(bus.m_cyc), 16'h0001);
        chk("ab_m_addr",  bus.m_addr,     16'h5555);
        chk("ab_m_we",    16'(bus.m_we),  16'h0001);
        chk("ab_m_wdata", bus.m_wdata,    16'h00AA);
        bus.s_cyc  = 3'b000;
        bus.s_addr = '0;
        bus.s_we   = 3'b000;
        tick();
        bus.m_ack   = 1'b1;
        bus.m_rdata = 16'h1111;
        #1;
        chk("ab_held_m_cyc",  16'(bus.m_cyc), 16'h0001);
        chk("ab_held_m_addr", bus.m_addr,     16'h5555);
        chk("ab_no_s_ack",    16'(bus.s_ack), 16'h0000);
        tick();
        bus.m_ack = 1'b0;
        #1;
        chk("ab_gap_m_cyc", 16'(bus.m_cyc), 16'h0000);
        tick();
        bus.s_addr = {16'h7777, 16'h0000, 16'h0000};
        bus.s_cyc  = 3'b100;
        tick();
        bus.m_ack = 1'b1;
        #1;
        chk("ab_next_m_addr", bus.m_addr,     16'h7777);
        chk("ab_next_s_ack",  16'(bus.s_ack), 16'h0004);
        tick();
        bus.m_ack = 1'b0;
        bus.s_cyc = 3'b000;
        tick();

        // Watchdog: master 0, slave never acks.
        bus.s_addr  = {16'h0000, 16'h0000, 16'h0ABC};
        bus.s_cyc   = 3'b001;
        bus.m_rdata = 16'h1234;
        tick();
        for (int b = 1; b < 8; b++) begin
            #1;
            chk("wd_wait_s_ack", 16'(bus.s_ack), 16'h0000);
            chk("wd_wait_err",   16'(bus.err),   16'h0000);
            chk("wd_wait_m_cyc", 16'(bus.m_cyc), 16'h0001);
            tick();
        end
        #1;
        chk("wd_s_ack",  16'(bus.s_ack), 16'h0001);
        chk("wd_err",    16'(bus.err),   16'h0001);
        chk("wd_rdata",  bus.s_rdata,    16'hFFFF);
        tick();
        #1;
        chk("wd_gap_m_cyc", 16'(bus.m_cyc), 16'h0000);
        chk("wd_gap_err",   16'(bus.err),   16'h0000);
        chk("wd_gap_s_ack", 16'(bus.s_ack), 16'h0000);
        tick();
        bus.s_cyc = 3'b000;
        bus.m_ack = 1'b1;
        #1;
        chk("late_s_ack", 16'(bus.s_ack), 16'h0000);
        chk("late_rdata", bus.s_rdata,    16'h0000);
        chk("late_err",   16'(bus.err),   16'h0000);
        tick();
        #1;
        chk("late_m_cyc", 16'(bus.m_cyc), 16'h0000);
        bus.m_ack = 1'b0;
        tick();

        // Collision: ack lands exactly on the expiry cycle of master 1.
        bus.s_addr = {16'h0000, 16'h4444, 16'h0000};
        bus.s_cyc  = 3'b010;
        tick();
        for (int b = 1; b < 8; b++) begin
            tick();
        end
        bus.m_ack   = 1'b1;
        bus.m_rdata = 16'hCAFE;
        #1;
        chk("col_s_ack", 16'(bus.s_ack), 16'h0002);
        chk("col_rdata", bus.s_rdata,    16'hCAFE);
        chk("col_err",   16'(bus.err),   16'h0000);
        tick();
        bus.m_ack = 1'b0;
        bus.s_cyc = 3'b000;
        #1;
        chk("col_gap_m_cyc", 16'(bus.m_cyc), 16'h0000);
        chk("col_gap_err",   16'(bus.err),   16'h0000);
        tick();

        // Reset in flight, on the cycle the watchdog would fire.
        bus.s_cyc = 3'b100;
        tick();
        for (int b = 1; b < 8; b++) begin
            tick();
        end
        rst = 1'b1;
        #1;
        chk("mr_m_cyc", 16'(bus.m_cyc), 16'h0000);
        chk("mr_s_ack", 16'(bus.s_ack), 16'h0000);
        chk("mr_err",   16'(bus.err),   16'h0000);
        rst = 1'b0;
        bus.s_addr = {16'h3000, 16'h2000, 16'h1000};
        bus.s_cyc  = 3'b111;
        tick();
        bus.m_ack = 1'b1;
        #1;
        chk("mr_prio_m_addr", bus.m_addr,     16'h1000);
        chk("mr_prio_s_ack",  16'(bus.s_ack), 16'h0001);
        tick();
        bus.m_ack = 1'b0;
        bus.s_cyc = 3'b000;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
